// File: rtl/audio_pkg.sv
// Shared types and widths for the tone generator: envelope states and datapath widths.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int AMP_W    = 24;
  localparam int SAMPLE_W = 32;
  localparam int HP_W     = 19;
  localparam int NOTE_W   = 4;

endpackage

// File: rtl/square_osc.sv
// Half-period counter and phase flip-flop for the square wave; clr restarts the wave at
// count 0 with the low phase.
module square_osc
  import audio_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [HP_W-1:0] half_period,
  output logic [HP_W-1:0] hp_cnt,
  output logic            phase
);

  logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    hp_cnt_d = hp_cnt_q + HP_W'(1);
    phase_d  = phase_q;
    if (clr) begin
      hp_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (hp_cnt_q == half_period) begin
      hp_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt_q <= '0;
      phase_q  <= 1'b0;
    end else begin
      hp_cnt_q <= hp_cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign hp_cnt = hp_cnt_q;
  assign phase  = phase_q;

endmodule

// File: rtl/tone_envelope_gen.sv
// Square-wave tone with attack/sustain/release amplitude envelope, stepped once per
// consumed codec sample so note on/off ramps instead of clicking.
module tone_envelope_gen
  import audio_pkg::*;
#(
  parameter logic [14:0] HP_LSB       = 15'd3000,
  parameter int unsigned AMP_MAX      = 10_000_000,
  parameter int unsigned ATTACK_STEP  = 100_000,
  parameter int unsigned RELEASE_STEP = 50_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NOTE_W-1:0]   note_sel,
  input  logic                sample_tick,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                active,
  output env_state_t          state_dbg
);

  localparam logic [AMP_W-1:0] AMP_MAX_V  = AMP_W'(AMP_MAX);
  localparam logic [AMP_W:0]   ATTACK_V   = (AMP_W + 1)'(ATTACK_STEP);
  localparam logic [AMP_W-1:0] RELEASE_V  = AMP_W'(RELEASE_STEP);

  env_state_t          state_q, state_d;
  logic [AMP_W-1:0]    amp_q, amp_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                active_q, active_d;
  logic [AMP_W:0]      amp_sum;
  logic [SAMPLE_W-1:0] amp_ext;
  logic [HP_W-1:0]     half_period;
  logic [HP_W-1:0]     hp_cnt;
  logic                phase;
  logic                note_chg;
  logic                osc_clr;

  assign half_period = {note_sel, HP_LSB};
  assign note_d      = note_sel;
  assign note_chg    = (note_sel != note_q);
  // A new nonzero note restarts the wave cleanly; IDLE parks it at count 0, low phase.
  assign osc_clr     = (state_q == IDLE) || (note_chg && (note_sel != '0));

  square_osc u_osc (
    .clk         (CLOCK_50),
    .rst         (reset),
    .clr         (osc_clr),
    .half_period (half_period),
    .hp_cnt      (hp_cnt),
    .phase       (phase)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Note off wins over reaching full amplitude while still in ATTACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (note_sel != '0) state_d = ATTACK;
      ATTACK:  if (note_sel == '0) state_d = RELEASE;
               else if (amp_q == AMP_MAX_V) state_d = SUSTAIN;
      SUSTAIN: if (note_sel == '0) state_d = RELEASE;
      RELEASE: if (note_sel != '0) state_d = ATTACK;
               else if (amp_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sample_tick is a one-cycle consume strobe from the mixer (no backpressure): each pulse
  // advances the envelope by one step using the state held at the start of that cycle.
  always_comb begin
    amp_sum = {1'b0, amp_q} + ATTACK_V;
    amp_d   = amp_q;
    if (sample_tick) begin
      case (state_q)
        ATTACK:  amp_d = (amp_sum > {1'b0, AMP_MAX_V}) ? AMP_MAX_V : amp_sum[AMP_W-1:0];
        RELEASE: amp_d = (amp_q < RELEASE_V) ? '0 : amp_q - RELEASE_V;
        default: amp_d = amp_q;
      endcase
    end
  end

  always_comb begin
    amp_ext  = SAMPLE_W'(amp_q);
    active_d = (state_d != IDLE);
    sample_d = '0;
    if (state_q != IDLE) sample_d = phase ? amp_ext : -amp_ext;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      amp_q    <= '0;
      note_q   <= '0;
      sample_q <= '0;
      active_q <= 1'b0;
    end else begin
      amp_q    <= amp_d;
      note_q   <= note_d;
      sample_q <= sample_d;
      active_q <= active_d;
    end
  end

  assign sample_out = sample_q;
  assign active     = active_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tone_envelope_gen.sv
// Bench for tone_envelope_gen: three instances run directed sequences in parallel; drivers
// queue cycle-tagged expectations and a negedge monitor pops and compares them.
module tb_tone_envelope_gen;
  import audio_pkg::*;

  typedef struct packed {
    int          cyc;
    logic [1:0]  inst;
    logic [31:0] sample;
    logic        active;
    logic [1:0]  state;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic [3:0]  note [3];
  logic        tick [3];
  logic [31:0] so   [3];
  logic        act  [3];
  env_state_t  st   [3];

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  exp_t  exp_q[$];
  string name_q[$];

  // clock / reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_envelope_gen dut0 (
    .CLOCK_50(clk), .reset(rst[0]), .note_sel(note[0]), .sample_tick(tick[0]),
    .sample_out(so[0]), .active(act[0]), .state_dbg(st[0])
  );

  tone_envelope_gen dut1 (
    .CLOCK_50(clk), .reset(rst[1]), .note_sel(note[1]), .sample_tick(tick[1]),
    .sample_out(so[1]), .active(act[1]), .state_dbg(st[1])
  );

  tone_envelope_gen #(.AMP_MAX(250_000), .RELEASE_STEP(60_000)) dut2 (
    .CLOCK_50(clk), .reset(rst[2]), .note_sel(note[2]), .sample_tick(tick[2]),
    .sample_out(so[2]), .active(act[2]), .state_dbg(st[2])
  );

  // driver tasks
  task automatic step(input int i, input logic [3:0] n, input logic t);
    note[i] = n;
    tick[i] = t;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int i, input string nm, input int amp_s, input logic a,
                          input env_state_t s);
    exp_t e;
    e.cyc    = cyc;
    e.inst   = 2'(i);
    e.sample = 32'(amp_s);
    e.active = a;
    e.state  = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic reset_seq(input int i);
    rst[i] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(i, 4'd5, 1'b0);
      push_exp(i, "reset_hold", 0, 1'b0, IDLE);
    end
    rst[i] = 1'b0;
    step(i, 4'd0, 1'b0);
    push_exp(i, "idle_after_reset", 0, 1'b0, IDLE);
  endtask

  // dut0: attack/sustain/release with note 1, same-cycle tick, reset mid-release
  task automatic run0();
    reset_seq(0);
    step(0, 4'd1, 1'b0);
    push_exp(0, "note_on", 0, 1'b1, ATTACK);
    for (int i = 1; i <= 100; i++) begin
      step(0, 4'd1, 1'b1);
      step(0, 4'd1, 1'b0);
      push_exp(0, "attack_ramp", -(i * 100_000), 1'b1, (i == 100) ? SUSTAIN : ATTACK);
      repeat (6) step(0, 4'd1, 1'b0);
    end
    for (int k = 0; k < 34969; k++) step(0, 4'd1, (k % 8 == 0));
    push_exp(0, "phase_before_edge", -10_000_000, 1'b1, SUSTAIN);
    step(0, 4'd1, 1'b0);
    push_exp(0, "phase_after_edge", 10_000_000, 1'b1, SUSTAIN);

    step(0, 4'd0, 1'b0);
    push_exp(0, "release_enter", 10_000_000, 1'b1, RELEASE);
    for (int i = 1; i <= 200; i++) begin
      step(0, 4'd0, 1'b1);
      step(0, 4'd0, 1'b0);
      if (i == 200) push_exp(0, "release_end", 0, 1'b0, IDLE);
      else          push_exp(0, "release_ramp", 10_000_000 - i * 50_000, 1'b1, RELEASE);
      repeat (6) step(0, 4'd0, 1'b0);
    end

    step(0, 4'd1, 1'b0);
    push_exp(0, "retrig_from_idle", 0, 1'b1, ATTACK);
    step(0, 4'd1, 1'b1); step(0, 4'd1, 1'b0);
    step(0, 4'd1, 1'b1); step(0, 4'd1, 1'b0);
    push_exp(0, "pre_same_cycle", -200_000, 1'b1, ATTACK);
    step(0, 4'd0, 1'b1);
    push_exp(0, "same_cycle_state", -200_000, 1'b1, RELEASE);
    step(0, 4'd0, 1'b0);
    push_exp(0, "same_cycle_amp", -300_000, 1'b1, RELEASE);
    step(0, 4'd0, 1'b1); step(0, 4'd0, 1'b0);
    push_exp(0, "release_mid", -250_000, 1'b1, RELEASE);
    rst[0] = 1'b1;
    step(0, 4'd0, 1'b0);
    push_exp(0, "reset_mid_release", 0, 1'b0, IDLE);
    rst[0] = 1'b0;
    step(0, 4'd0, 1'b1);
    push_exp(0, "no_release_tail", 0, 1'b0, IDLE);
    step(0, 4'd0, 1'b0);
    push_exp(0, "no_release_tail2", 0, 1'b0, IDLE);
  endtask

  // dut1: retrigger from RELEASE at 3_000_000 with note 2, half period 68_536
  task automatic run1();
    reset_seq(1);
    step(1, 4'd1, 1'b0);
    push_exp(1, "t4_note_on", 0, 1'b1, ATTACK);
    for (int i = 1; i <= 30; i++) begin
      step(1, 4'd1, 1'b1);
      step(1, 4'd1, 1'b0);
    end
    push_exp(1, "t4_amp_3m", -3_000_000, 1'b1, ATTACK);
    step(1, 4'd0, 1'b0);
    push_exp(1, "t4_release", -3_000_000, 1'b1, RELEASE);
    step(1, 4'd2, 1'b0);
    push_exp(1, "t4_retrigger", -3_000_000, 1'b1, ATTACK);
    step(1, 4'd2, 1'b1);
    push_exp(1, "t4_tick_cycle", -3_000_000, 1'b1, ATTACK);
    step(1, 4'd2, 1'b0);
    push_exp(1, "t4_resume", -3_100_000, 1'b1, ATTACK);
    repeat (68535) step(1, 4'd2, 1'b0);
    push_exp(1, "t4_before_edge", -3_100_000, 1'b1, ATTACK);
    step(1, 4'd2, 1'b0);
    push_exp(1, "t4_after_edge", 3_100_000, 1'b1, ATTACK);
  endtask

  // dut2: AMP_MAX=250_000, RELEASE_STEP=60_000 -> clamp on attack, floor at 0 on release
  task automatic run2();
    int rel_exp [5];
    rel_exp = '{190_000, 130_000, 70_000, 10_000, 0};
    reset_seq(2);
    step(2, 4'd3, 1'b0);
    push_exp(2, "t5_note_on", 0, 1'b1, ATTACK);
    step(2, 4'd3, 1'b1); step(2, 4'd3, 1'b0);
    push_exp(2, "t5_tick1", -100_000, 1'b1, ATTACK);
    step(2, 4'd3, 1'b1); step(2, 4'd3, 1'b0);
    push_exp(2, "t5_tick2", -200_000, 1'b1, ATTACK);
    step(2, 4'd3, 1'b1); step(2, 4'd3, 1'b0);
    push_exp(2, "t5_clamp", -250_000, 1'b1, SUSTAIN);
    step(2, 4'd3, 1'b1); step(2, 4'd3, 1'b0);
    push_exp(2, "t5_sustain_hold", -250_000, 1'b1, SUSTAIN);
    step(2, 4'd0, 1'b0);
    push_exp(2, "t5_release", -250_000, 1'b1, RELEASE);
    for (int i = 0; i < 5; i++) begin
      step(2, 4'd0, 1'b1);
      step(2, 4'd0, 1'b0);
      if (i == 4) push_exp(2, "t5_underflow", 0, 1'b0, IDLE);
      else        push_exp(2, "t5_release_ramp", -rel_exp[i], 1'b1, RELEASE);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t  e;
    string nm;
    int    k;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      k  = int'(e.inst);
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s inst%0d: expectation due at cycle %0d seen at cycle %0d",
                 nm, k, e.cyc, cyc);
      end else if (so[k] !== e.sample || act[k] !== e.active || st[k] !== e.state) begin
        failures++;
        $display("FAIL %s inst%0d cyc%0d: got sample=%0d active=%0b state=%0d, want sample=%0d active=%0b state=%0d",
                 nm, k, cyc, $signed(so[k]), act[k], st[k], $signed(e.sample), e.active, e.state);
      end
    end
  end

  initial begin
    #(20 * 120_000);
    $display("FAIL watchdog: run exceeded 120000 cycles");
    $fatal(1, "watchdog expired");
  end

  // final report
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      note[i] = 4'd0;
      tick[i] = 1'b0;
    end
    fork
      run0();
      run1();
      run2();
    join
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
